// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioner: hold-FSM states,
// default timing at 24 MHz, and a counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } hold_state_e;

    localparam int CLK_HZ               = 24000000;
    localparam int DEF_DEBOUNCE_CYCLES  = CLK_HZ / 100;  // 10 ms
    localparam int DEF_HOLD_CYCLES      = CLK_HZ / 2;    // 500 ms
    localparam int DEF_REPEAT_CYCLES    = CLK_HZ / 8;    // 125 ms

    // A count of 1 still needs a 1-bit register, so never return 0.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key inputs and conditioned event/level outputs, one bit per key channel.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] repeat_pulse;

    modport master (
        output KEY,
        input  pressed, press_pulse, release_pulse, held, repeat_pulse
    );

    modport slave (
        input  KEY,
        output pressed, press_pulse, release_pulse, held, repeat_pulse
    );
endinterface

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce, and hold/auto-repeat FSM.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic repeat_pulse
);
    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam int HC_W = cnt_w(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] RPT_LAST  = HC_W'(REPEAT_CYCLES - 1);

    logic            ff1_q, ff1_d, ff2_q, ff2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d, rel_q, rel_d;
    hold_state_e     state_q, state_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            held_q, held_d, rpt_q, rpt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff1_q      <= 1'b0;
            ff2_q      <= 1'b0;
            stable_q   <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            ff1_q      <= ff1_d;
            ff2_q      <= ff2_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
            rpt_q      <= rpt_d;
        end
    end

    // Debounce: any sample agreeing with the accepted level restarts the count.
    always_comb begin
        ff1_d    = ~key_n;
        ff2_d    = ff1_q;
        stable_d = stable_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        if (ff2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ff2_q;
                press_d  = ff2_q;
                rel_d    = ~ff2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Hold FSM reacts to the accept event on the same edge as the pulse register.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        held_d     = held_q;
        rpt_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_d) begin
                    state_d    = ST_DOWN;
                    hold_cnt_d = '0;
                end
            end
            ST_DOWN: begin
                if (rel_d) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    held_d     = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_HELD;
                    hold_cnt_d = '0;
                    held_d     = 1'b1;
                    rpt_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (rel_d) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    held_d     = 1'b0;
                end else if (hold_cnt_q == RPT_LAST) begin
                    hold_cnt_d = '0;
                    rpt_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                held_d     = 1'b0;
            end
        endcase
    end

    assign pressed       = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign held          = held_q;
    assign repeat_pulse  = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw active-low buttons into clean press/release/repeat
// events and pressed/held levels for the time-set logic.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input logic         CLOCK_24,
    input logic         RESET_N,
    key_conditioner_if.slave kif
);
    logic [NUM_KEYS-1:0] pressed_w, press_w, rel_w, held_w, rpt_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (CLOCK_24),
            .rst_n         (RESET_N),
            .key_n         (kif.KEY[i]),
            .pressed       (pressed_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (rel_w[i]),
            .held          (held_w[i]),
            .repeat_pulse  (rpt_w[i])
        );
    end

    assign kif.pressed       = pressed_w;
    assign kif.press_pulse   = press_w;
    assign kif.release_pulse = rel_w;
    assign kif.held          = held_w;
    assign kif.repeat_pulse  = rpt_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed stimulus for key_conditioner, compared every cycle
// against a timing model expressed as "cycles since accepted press".
module tb_key_conditioner;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .CLOCK_24 (clk),
        .RESET_N  (rst_n),
        .kif      (kif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pp0_cnt  = 0;
    int rp0_cnt  = 0;

    // Reference model state per key
    int m_a [NK];       // level seen one edge ago (1 = down)
    int m_b [NK];       // level seen two edges ago
    int m_stable [NK];
    int m_run [NK];     // consecutive edges the synchronised level disagreed
    int m_t [NK];       // edges since the press was accepted
    logic [NK-1:0] m_pressed, m_pp, m_rp, m_held, m_rpt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic [NK-1:0] key, input logic rstn);
        for (int i = 0; i < NK; i++) begin
            int  d;
            bit  changed;
            m_pp[i]  = 1'b0;
            m_rp[i]  = 1'b0;
            m_rpt[i] = 1'b0;
            changed  = 1'b0;
            if (!rstn) begin
                m_a[i] = 0; m_b[i] = 0; m_stable[i] = 0; m_run[i] = 0; m_t[i] = 0;
                m_held[i] = 1'b0;
            end else begin
                d      = m_b[i];
                m_b[i] = m_a[i];
                m_a[i] = key[i] ? 0 : 1;
                if (d != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_run[i]    = 0;
                        m_stable[i] = d;
                        changed     = 1'b1;
                        if (d == 1) begin
                            m_pp[i] = 1'b1;
                            m_t[i]  = 0;
                        end else begin
                            m_rp[i]   = 1'b1;
                            m_held[i] = 1'b0;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (!changed && m_stable[i] == 1) begin
                    m_t[i]++;
                    if (m_t[i] >= H) m_held[i] = 1'b1;
                    if (m_t[i] == H || (m_t[i] > H && (m_t[i] - H) % R == 0))
                        m_rpt[i] = 1'b1;
                end
            end
            m_pressed[i] = (m_stable[i] == 1);
        end
    endtask

    task automatic tick(input logic [NK-1:0] key, input logic rstn);
        @(negedge clk);
        kif.KEY = key;
        rst_n   = rstn;
        @(posedge clk);
        cyc++;
        model_step(key, rstn);
        #1;
        chk("pressed",       32'(kif.pressed),       32'(m_pressed));
        chk("press_pulse",   32'(kif.press_pulse),   32'(m_pp));
        chk("release_pulse", 32'(kif.release_pulse), 32'(m_rp));
        chk("held",          32'(kif.held),          32'(m_held));
        chk("repeat_pulse",  32'(kif.repeat_pulse),  32'(m_rpt));
        if (kif.press_pulse[0])   pp0_cnt++;
        if (kif.release_pulse[0]) rp0_cnt++;
    endtask

    int rem [NK];
    logic [NK-1:0] rkey;

    initial begin
        kif.KEY = '1;
        rst_n   = 1'b0;
        for (int i = 0; i < NK; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_stable[i] = 0; m_run[i] = 0; m_t[i] = 0;
        end
        m_pressed = '0; m_pp = '0; m_rp = '0; m_held = '0; m_rpt = '0;

        // Reset, then idle
        repeat (3)  tick(2'b11, 1'b0);
        repeat (50) tick(2'b11, 1'b1);

        // Clean press and release of key 0
        repeat (12) tick(2'b10, 1'b1);
        repeat (12) tick(2'b11, 1'b1);

        // Bouncing press, then a long hold through several repeats
        pp0_cnt = 0;
        rp0_cnt = 0;
        repeat (3)  tick(2'b10, 1'b1);
        repeat (1)  tick(2'b11, 1'b1);
        repeat (2)  tick(2'b10, 1'b1);
        repeat (1)  tick(2'b11, 1'b1);
        repeat (70) tick(2'b10, 1'b1);
        chk("bounce_press_count",   32'(pp0_cnt), 32'd1);
        chk("bounce_release_count", 32'(rp0_cnt), 32'd0);

        // Release while held
        repeat (20) tick(2'b11, 1'b1);
        chk("hold_release_count", 32'(rp0_cnt), 32'd1);

        // Both keys together, reset mid-hold, still down after reset
        repeat (15) tick(2'b00, 1'b1);
        repeat (2)  tick(2'b00, 1'b0);
        repeat (40) tick(2'b00, 1'b1);
        repeat (20) tick(2'b11, 1'b1);

        // Random bouncing/holding with occasional resets
        for (int i = 0; i < NK; i++) rem[i] = 0;
        rkey = '1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    rkey[i] = 1'($urandom_range(0, 1));
                    rem[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 8));
                end
                rem[i]--;
            end
            tick(rkey, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
